// File: rtl/jt12_op_acc.sv
// jt12_op_acc: sums carrier operator samples per channel and mixes a round.
// Ports:
//   clk, rst_n (sync, active-low), clk_en (slot strobe), zero (slot 0 mark)
//   s1..s4_enters (operator of current slot), alg (channel algorithm)
//   op_result (signed sample) -> ch_out/ch_idx/ch_valid, mix_out/mix_valid,
//   sat_flag (a write clipped), desync (zero seen off slot 23)
module jt12_op_acc #(
    parameter int OP_W  = 9,
    parameter int ACC_W = 12,
    parameter int MIX_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic                    zero,
    input  logic                    s1_enters,
    input  logic                    s2_enters,
    input  logic                    s3_enters,
    input  logic                    s4_enters,
    input  logic [2:0]              alg,
    input  logic signed [OP_W-1:0]  op_result,
    output logic signed [ACC_W-1:0] ch_out,
    output logic [2:0]              ch_idx,
    output logic                    ch_valid,
    output logic signed [MIX_W-1:0] mix_out,
    output logic                    mix_valid,
    output logic                    sat_flag,
    output logic                    desync
);
    // Six channel values of ACC_W bits always fit in ACC_W+3 bits,
    // so the mix accumulator itself never needs clipping.
    localparam int MA_W = ACC_W + 3;
    localparam int SW   = ((MA_W > MIX_W) ? MA_W : MIX_W) + 1;

    typedef enum logic {UNSYNC, RUN} state_t;

    state_t     state, state_nx;
    logic [4:0] slot_q, slot_nx;
    logic [2:0] ch_q, ch_nx;
    logic       active, desync_nx;

    logic signed [ACC_W-1:0] acc [6];
    logic signed [MA_W-1:0]  mix_acc;

    logic                    one_hot, sum_en, wr;
    logic signed [ACC_W-1:0] term, acc_cur, acc_sat, new_val;
    logic signed [ACC_W:0]   acc_sum;
    logic                    acc_fit, acc_clip;
    logic signed [MA_W-1:0]  mix_base, mix_sum;
    logic signed [SW-1:0]    mix_w;
    logic signed [MIX_W-1:0] mix_sat;
    logic                    mix_fit, mix_end, mix_clip;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= UNSYNC;
            slot_q <= '0;
            ch_q   <= '0;
        end else begin
            state  <= state_nx;
            slot_q <= slot_nx;
            ch_q   <= ch_nx;
        end
    end

    // Slot tracking: zero always forces slot 0; otherwise advance in RUN.
    always_comb begin
        state_nx  = state;
        slot_nx   = slot_q;
        ch_nx     = ch_q;
        active    = 1'b0;
        desync_nx = 1'b0;
        if (clk_en) begin
            if (zero) begin
                state_nx  = RUN;
                slot_nx   = '0;
                ch_nx     = '0;
                active    = 1'b1;
                desync_nx = (state == RUN) && (slot_q != 5'd23);
            end else if (state == RUN) begin
                active = 1'b1;
                if (slot_q == 5'd23) begin
                    slot_nx = '0;
                    ch_nx   = '0;
                end else begin
                    slot_nx = slot_q + 5'd1;
                    ch_nx   = (ch_q == 3'd5) ? 3'd0 : ch_q + 3'd1;
                end
            end
        end
    end

    always_comb begin
        case (alg)
            3'd0, 3'd1,
            3'd2, 3'd3: sum_en = s4_enters;
            3'd4:       sum_en = s2_enters | s4_enters;
            3'd5, 3'd6: sum_en = ~s1_enters;
            default:    sum_en = 1'b1;
        endcase
    end

    always_comb begin
        one_hot = $onehot({s1_enters, s2_enters, s3_enters, s4_enters});
        wr      = active & one_hot;
        term    = sum_en ? ACC_W'(op_result) : '0;
        acc_cur = acc[ch_nx];
        acc_sum = (ACC_W+1)'(acc_cur) + (ACC_W+1)'(term);
        acc_fit = acc_sum[ACC_W] == acc_sum[ACC_W-1];
        acc_sat = acc_fit ? acc_sum[ACC_W-1:0]
                          : {acc_sum[ACC_W], {(ACC_W-1){~acc_sum[ACC_W]}}};
        new_val  = s1_enters ? term : acc_sat;
        acc_clip = wr & ~s1_enters & ~acc_fit;

        // A desync discards whatever partial round was accumulated.
        mix_base = desync_nx ? '0 : mix_acc;
        mix_sum  = mix_base + MA_W'(new_val);
        mix_w    = SW'(mix_sum);
        mix_fit  = (&mix_w[SW-1:MIX_W-1]) | ~(|mix_w[SW-1:MIX_W-1]);
        mix_sat  = mix_fit ? mix_w[MIX_W-1:0]
                           : {mix_w[SW-1], {(MIX_W-1){~mix_w[SW-1]}}};
        mix_end  = wr & s4_enters & (ch_nx == 3'd5);
        mix_clip = mix_end & ~mix_fit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) acc[i] <= '0;
            mix_acc   <= '0;
            ch_out    <= '0;
            ch_idx    <= '0;
            ch_valid  <= 1'b0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            sat_flag  <= 1'b0;
            desync    <= 1'b0;
        end else begin
            ch_valid  <= 1'b0;
            mix_valid <= 1'b0;
            sat_flag  <= acc_clip | mix_clip;
            desync    <= desync_nx;
            if (active) mix_acc <= mix_base;
            if (wr) begin
                acc[ch_nx] <= new_val;
                if (s4_enters) begin
                    ch_out   <= new_val;
                    ch_idx   <= ch_nx;
                    ch_valid <= 1'b1;
                    if (mix_end) begin
                        mix_out   <= mix_sat;
                        mix_valid <= 1'b1;
                        mix_acc   <= '0;
                    end else begin
                        mix_acc <= mix_sum;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_jt12_op_acc.sv
// Directed bench for jt12_op_acc: default instance plus a narrow instance
// (ACC_W=10, MIX_W=12) driven by the same slot stream.
module tb_jt12_op_acc;
    logic clk = 1'b0;
    logic rst_n, clk_en, zero;
    logic s1, s2, s3, s4;
    logic [2:0] alg;
    logic signed [8:0] op;

    logic signed [11:0] ch_out;
    logic [2:0]         ch_idx;
    logic               ch_valid, mix_valid, sat_flag, desync;
    logic signed [15:0] mix_out;

    logic signed [9:0]  chb_out;
    logic [2:0]         chb_idx;
    logic               chb_valid, mixb_valid, satb, desyncb;
    logic signed [11:0] mixb_out;

    int errors = 0;
    int checks = 0;

    logic signed [11:0] chv [6];
    logic signed [9:0]  chvb [6];
    logic signed [15:0] mixv;
    logic signed [11:0] mixvb;
    int nv, nm, nsat, nsatb, ndes, des_at, mix_at, idx_bad, stray;

    always #5 clk = ~clk;

    jt12_op_acc dut_a (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .zero(zero),
        .s1_enters(s1), .s2_enters(s2), .s3_enters(s3), .s4_enters(s4),
        .alg(alg), .op_result(op),
        .ch_out(ch_out), .ch_idx(ch_idx), .ch_valid(ch_valid),
        .mix_out(mix_out), .mix_valid(mix_valid),
        .sat_flag(sat_flag), .desync(desync)
    );

    jt12_op_acc #(.OP_W(9), .ACC_W(10), .MIX_W(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .zero(zero),
        .s1_enters(s1), .s2_enters(s2), .s3_enters(s3), .s4_enters(s4),
        .alg(alg), .op_result(op),
        .ch_out(chb_out), .ch_idx(chb_idx), .ch_valid(chb_valid),
        .mix_out(mixb_out), .mix_valid(mixb_valid),
        .sat_flag(satb), .desync(desyncb)
    );

    task clear_cap();
        for (int i = 0; i < 6; i++) begin
            chv[i] = '0;
            chvb[i] = '0;
        end
        mixv = '0; mixvb = '0;
        nv = 0; nm = 0; nsat = 0; nsatb = 0; ndes = 0;
        des_at = -1; mix_at = -1; idx_bad = 0; stray = 0;
    endtask

    // Slot order: 0-5 S1, 6-11 S3, 12-17 S2, 18-23 S4; channel = slot % 6.
    task run_slots(input int first, input int n, input bit z,
                   input logic [2:0] a, input int o1, input int o2,
                   input int o3, input int o4, input bit gap,
                   input int noflag);
        int sl, grp;
        for (int k = 0; k < n; k++) begin
            sl  = (first + k) % 24;
            grp = sl / 6;
            @(negedge clk);
            clk_en = 1'b1;
            zero = z && (k == 0);
            s1 = (grp == 0); s3 = (grp == 1);
            s2 = (grp == 2); s4 = (grp == 3);
            if (sl == noflag) begin
                s1 = 1'b0; s2 = 1'b0; s3 = 1'b0; s4 = 1'b0;
            end
            op = (grp == 0) ? 9'(o1) : (grp == 1) ? 9'(o3) :
                 (grp == 2) ? 9'(o2) : 9'(o4);
            alg = a;
            @(posedge clk);
            #1;
            if (ch_valid) begin
                chv[ch_idx] = ch_out;
                nv++;
                if (int'(ch_idx) != sl % 6 || grp != 3) idx_bad++;
            end
            if (chb_valid) chvb[chb_idx] = chb_out;
            if (mix_valid) begin mixv = mix_out; nm++; mix_at = k; end
            if (mixb_valid) mixvb = mixb_out;
            if (sat_flag) nsat++;
            if (satb) nsatb++;
            if (desync) begin ndes++; des_at = k; end
            if (gap) begin
                @(negedge clk);
                clk_en = 1'b0;
                zero = 1'b0;
                @(posedge clk);
                #1;
                if (ch_valid | mix_valid | sat_flag | desync | chb_valid | satb)
                    stray++;
            end
        end
    endtask

    task reset_cycle();
        @(negedge clk);
        rst_n = 1'b0;
        clk_en = 1'b1;
        zero = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({ch_out, ch_idx, ch_valid, mix_out, mix_valid, sat_flag, desync} !== '0) begin
            errors++;
            $display("FAIL reset_a: got ch_out=%0d idx=%0d mix=%0d v=%b%b", ch_out, ch_idx, mix_out, ch_valid, mix_valid);
        end
        checks++;
        if ({chb_out, chb_idx, chb_valid, mixb_out, mixb_valid, satb, desyncb} !== '0) begin
            errors++;
            $display("FAIL reset_b: got ch_out=%0d mix=%0d want 0", chb_out, mixb_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task test_reset();
        rst_n = 1'b0; clk_en = 1'b0; zero = 1'b0;
        s1 = 1'b0; s2 = 1'b0; s3 = 1'b0; s4 = 1'b0;
        alg = '0; op = '0;
        repeat (2) @(posedge clk);
        reset_cycle();
    endtask

    task test_unsync();
        clear_cap();
        run_slots(0, 48, 1'b0, 3'd7, 10, 10, 10, 10, 1'b0, -1);
        checks++;
        if (nv + nm + ndes + nsat != 0) begin
            errors++;
            $display("FAIL unsync_silent: got %0d pulses want 0", nv + nm + ndes + nsat);
        end
    endtask

    task test_alg0();
        clear_cap();
        run_slots(0, 24, 1'b1, 3'd0, 10, 10, 10, 10, 1'b0, -1);
        checks++;
        if (nv != 6 || idx_bad != 0) begin
            errors++;
            $display("FAIL alg0_valid: got %0d pulses bad_idx=%0d want 6/0", nv, idx_bad);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (chv[i] !== 12'sd10) begin
                errors++;
                $display("FAIL alg0_ch%0d: got %0d want 10", i, chv[i]);
            end
        end
        checks++;
        if (nm != 1 || mixv !== 16'sd60 || ndes != 0) begin
            errors++;
            $display("FAIL alg0_mix: got %0d (n=%0d des=%0d) want 60", mixv, nm, ndes);
        end
        clear_cap();
        run_slots(0, 24, 1'b0, 3'd0, 3, 3, 3, 3, 1'b0, -1);
        checks++;
        if (nm != 1 || mixv !== 16'sd18) begin
            errors++;
            $display("FAIL alg0_wrap_mix: got %0d want 18", mixv);
        end
        clear_cap();
        run_slots(0, 24, 1'b1, 3'd1, -7, 50, 50, -7, 1'b0, -1);
        checks++;
        if (ndes != 0 || mixv !== -16'sd42) begin
            errors++;
            $display("FAIL alg1_zero_aligned: got mix=%0d des=%0d want -42/0", mixv, ndes);
        end
    endtask

    task test_sat();
        clear_cap();
        run_slots(0, 24, 1'b0, 3'd7, 255, 255, 255, 255, 1'b0, -1);
        checks++;
        if (chv[3] !== 12'sd1020 || mixv !== 16'sd6120 || nsat != 0) begin
            errors++;
            $display("FAIL alg7_pos_a: got ch=%0d mix=%0d sat=%0d want 1020/6120/0", chv[3], mixv, nsat);
        end
        checks++;
        if (chvb[5] !== 10'sd511 || nsatb != 12 || mixvb !== 12'sd2047) begin
            errors++;
            $display("FAIL alg7_pos_b: got ch=%0d sat=%0d mix=%0d want 511/12/2047", chvb[5], nsatb, mixvb);
        end
        clear_cap();
        run_slots(0, 24, 1'b0, 3'd7, -256, -256, -256, -256, 1'b0, -1);
        checks++;
        if (chv[0] !== -12'sd1024 || mixv !== -16'sd6144) begin
            errors++;
            $display("FAIL alg7_neg_a: got ch=%0d mix=%0d want -1024/-6144", chv[0], mixv);
        end
        checks++;
        if (chvb[1] !== -10'sd512 || nsatb != 12 || mixvb !== -12'sd2048) begin
            errors++;
            $display("FAIL alg7_neg_b: got ch=%0d sat=%0d mix=%0d want -512/12/-2048", chvb[1], nsatb, mixvb);
        end
        clear_cap();
        run_slots(0, 24, 1'b0, 3'd4, 0, 255, 0, 255, 1'b0, -1);
        checks++;
        if (chvb[4] !== 10'sd510 || nsatb != 1 || mixvb !== 12'sd2047) begin
            errors++;
            $display("FAIL mix_only_sat_b: got ch=%0d sat=%0d mix=%0d want 510/1/2047", chvb[4], nsatb, mixvb);
        end
    endtask

    task test_alg_select();
        clear_cap();
        run_slots(0, 24, 1'b0, 3'd4, 100, 7, 100, -20, 1'b0, -1);
        checks++;
        if (chv[2] !== -12'sd13 || idx_bad != 0) begin
            errors++;
            $display("FAIL alg4_ch2: got %0d want -13", chv[2]);
        end
        clear_cap();
        run_slots(0, 24, 1'b0, 3'd5, 100, 7, 100, -20, 1'b0, -1);
        checks++;
        if (chv[2] !== 12'sd87) begin
            errors++;
            $display("FAIL alg5_ch2: got %0d want 87", chv[2]);
        end
        clear_cap();
        run_slots(0, 24, 1'b0, 3'd6, 100, 7, 100, -20, 1'b0, -1);
        checks++;
        if (chv[2] !== 12'sd87 || mixv !== 16'sd522) begin
            errors++;
            $display("FAIL alg6: got ch=%0d mix=%0d want 87/522", chv[2], mixv);
        end
    endtask

    task test_gap_and_noflag();
        clear_cap();
        run_slots(0, 24, 1'b0, 3'd7, 10, 10, 10, 10, 1'b1, -1);
        checks++;
        if (chv[4] !== 12'sd40 || mixv !== 16'sd240 || stray != 0 || nv != 6) begin
            errors++;
            $display("FAIL clk_en_gap: got ch=%0d mix=%0d stray=%0d want 40/240/0", chv[4], mixv, stray);
        end
        clear_cap();
        run_slots(0, 24, 1'b0, 3'd7, 10, 10, 10, 10, 1'b0, 20);
        checks++;
        if (nv != 5 || mixv !== 16'sd200 || chv[3] !== 12'sd40) begin
            errors++;
            $display("FAIL noflag_slot: got n=%0d mix=%0d ch3=%0d want 5/200/40", nv, mixv, chv[3]);
        end
        clear_cap();
        run_slots(0, 24, 1'b0, 3'd7, 10, 10, 10, 10, 1'b0, -1);
        checks++;
        if (mixv !== 16'sd240) begin
            errors++;
            $display("FAIL noflag_recover: got %0d want 240", mixv);
        end
    endtask

    task test_desync();
        int cut [2];
        cut[0] = 10;
        cut[1] = 21;
        for (int j = 0; j < 2; j++) begin
            run_slots(0, cut[j], 1'b0, 3'd7, 10, 10, 10, 10, 1'b0, -1);
            clear_cap();
            run_slots(0, 24, 1'b1, 3'd7, 20, 20, 20, 20, 1'b0, -1);
            checks++;
            if (ndes != 1 || des_at != 0) begin
                errors++;
                $display("FAIL desync_pulse_%0d: got n=%0d at=%0d want 1/0", cut[j], ndes, des_at);
            end
            checks++;
            if (nm != 1 || mix_at != 23 || mixv !== 16'sd480) begin
                errors++;
                $display("FAIL desync_mix_%0d: got %0d at=%0d want 480 at 23", cut[j], mixv, mix_at);
            end
        end
    endtask

    task test_reset_mid();
        run_slots(0, 15, 1'b0, 3'd7, 10, 10, 10, 10, 1'b0, -1);
        reset_cycle();
        clear_cap();
        run_slots(16, 24, 1'b0, 3'd7, 10, 10, 10, 10, 1'b0, -1);
        checks++;
        if (nv + nm + ndes != 0 || ch_out !== '0 || mix_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_silent: got %0d pulses ch=%0d", nv + nm + ndes, ch_out);
        end
        clear_cap();
        run_slots(0, 24, 1'b1, 3'd0, 5, 5, 5, 5, 1'b0, -1);
        checks++;
        if (chv[5] !== 12'sd5 || mixv !== 16'sd30 || ndes != 0) begin
            errors++;
            $display("FAIL reset_mid_resync: got ch=%0d mix=%0d des=%0d want 5/30/0", chv[5], mixv, ndes);
        end
    endtask

    initial begin
        test_reset();
        test_unsync();
        test_alg0();
        test_sat();
        test_alg_select();
        test_gap_and_noflag();
        test_desync();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
